rf_wb_arbiter: RTL and testbench

RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

---
 rtl/wb_pkg.sv | 19 +
 rtl/wb_fifo.sv | 91 +++++++++
 rtl/rf_wb_arbiter.sv | 146 ++++++++++++++
 tb/tb_rf_wb_arbiter.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and sizing for the register-file writeback arbiter and its queue.
package wb_pkg;

  localparam int WB_DEPTH = 2;

  // Pointer width for a queue of the given depth; never narrower than one bit.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int WB_PTR_W = ptr_width(WB_DEPTH);

  typedef struct packed {
    logic        valid;
    logic [3:0]  sel;
    logic [31:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Circular writeback queue. Entries can be invalidated in place by selector;
// occupied slots are exposed oldest-first for forwarding and head arbitration.
module wb_fifo
  import wb_pkg::*;
#(
  parameter  int DEPTH = WB_DEPTH,
  localparam int PTR_W = ptr_width(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  enq_i,
  input  wb_entry_t             enq_entry_i,
  input  logic                  deq_i,
  input  logic                  inv_en_i,
  input  logic [3:0]            inv_sel_i,
  output wb_entry_t [DEPTH-1:0] age_o,
  output logic [CNT_W-1:0]      count_o,
  output logic                  full_o
);

  wb_entry_t [DEPTH-1:0] ent_q, ent_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  do_enq, do_deq;
  int                    age_idx;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign count_o = cnt_q;
  assign do_deq  = deq_i && (cnt_q != '0);
  assign do_enq  = enq_i && (!full_o || do_deq);

  // Next queue state: invalidate by selector first, then pop, then push.
  always_comb begin
    ent_d    = ent_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (inv_en_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (ent_q[i].sel == inv_sel_i) ent_d[i].valid = 1'b0;
      end
    end
    if (do_deq) begin
      ent_d[rd_ptr_q].valid = 1'b0;
      rd_ptr_d              = ptr_inc(rd_ptr_q);
    end
    if (do_enq) begin
      ent_d[wr_ptr_q] = enq_entry_i;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    case ({do_enq, do_deq})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Age-ordered readout: slot 0 is the head; slots beyond occupancy read invalid.
  always_comb begin
    age_o   = '0;
    age_idx = 0;
    for (int k = 0; k < DEPTH; k++) begin
      age_idx = int'(rd_ptr_q) + k;
      if (age_idx >= DEPTH) age_idx = age_idx - DEPTH;
      age_o[k] = ent_q[age_idx[PTR_W-1:0]];
      if (CNT_W'(k) >= cnt_q) age_o[k].valid = 1'b0;
    end
  end

  // Queue state registers; reset empties the queue and drops every entry.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ent_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      ent_q    <= ent_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write port arbiter: mem loads win, queued exec writes drain
// oldest-first, and exec writes go direct only when nothing is queued.
module rf_wb_arbiter #(
  parameter int WB_DEPTH = wb_pkg::WB_DEPTH
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        ex_wr_en_i,
  input  logic [3:0]  ex_wr_sel_i,
  input  logic [31:0] ex_wr_data_i,
  input  logic        ex_sp_wr_en_i,
  input  logic [31:0] ex_sp_data_i,
  input  logic        mem_wr_en_i,
  input  logic [3:0]  mem_wr_sel_i,
  input  logic [31:0] mem_wr_data_i,
  input  logic [3:0]  rd0_sel_i,
  input  logic [3:0]  rd1_sel_i,
  output logic        rf_wr_en_o,
  output logic [3:0]  rf_wr_select_o,
  output logic [31:0] rf_wr_data_o,
  output logic        rf_sp_wr_en_o,
  output logic [31:0] rf_sp_data_o,
  output logic        fwd0_hit_o,
  output logic [31:0] fwd0_data_o,
  output logic        fwd1_hit_o,
  output logic [31:0] fwd1_data_o,
  output logic        stall_o,
  output logic [1:0]  pending_o
);
  import wb_pkg::*;

  localparam int CNT_W = $clog2(WB_DEPTH + 1);

  wb_entry_t [WB_DEPTH-1:0] q_age;
  logic [CNT_W-1:0]         q_count;
  logic                     q_full, q_empty, q_enq, q_deq, ex_req;
  wb_entry_t                ex_entry;

  logic        rf_wr_en_q, rf_wr_en_d;
  logic [3:0]  rf_wr_sel_q, rf_wr_sel_d;
  logic [31:0] rf_wr_data_q, rf_wr_data_d;
  logic        rf_sp_wr_en_q, rf_sp_wr_en_d;
  logic [31:0] rf_sp_data_q, rf_sp_data_d;

  // Exec writes arriving while full are dropped; the pipeline is expected to hold them.
  assign ex_req   = ex_wr_en_i && !q_full;
  assign ex_entry = '{valid: 1'b1, sel: ex_wr_sel_i, data: ex_wr_data_i};
  assign q_empty  = (q_count == '0);

  wb_fifo #(.DEPTH(WB_DEPTH)) u_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .enq_i       (q_enq),
    .enq_entry_i (ex_entry),
    .deq_i       (q_deq),
    .inv_en_i    (mem_wr_en_i),
    .inv_sel_i   (mem_wr_sel_i),
    .age_o       (q_age),
    .count_o     (q_count),
    .full_o      (q_full)
  );

  // Grant: mem, else queue head (dead heads pop silently), else direct exec.
  always_comb begin
    rf_wr_en_d    = 1'b0;
    rf_wr_sel_d   = '0;
    rf_wr_data_d  = '0;
    q_enq         = 1'b0;
    q_deq         = 1'b0;
    rf_sp_wr_en_d = ex_sp_wr_en_i;
    rf_sp_data_d  = ex_sp_data_i;
    if (mem_wr_en_i) begin
      rf_wr_en_d   = 1'b1;
      rf_wr_sel_d  = mem_wr_sel_i;
      rf_wr_data_d = mem_wr_data_i;
      q_enq        = ex_req;
    end else if (!q_empty) begin
      q_deq = 1'b1;
      q_enq = ex_req;
      if (q_age[0].valid) begin
        rf_wr_en_d   = 1'b1;
        rf_wr_sel_d  = q_age[0].sel;
        rf_wr_data_d = q_age[0].data;
      end
    end else if (ex_req) begin
      rf_wr_en_d   = 1'b1;
      rf_wr_sel_d  = ex_wr_sel_i;
      rf_wr_data_d = ex_wr_data_i;
    end
  end

  // Write-port and SP output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rf_wr_en_q    <= 1'b0;
      rf_wr_sel_q   <= '0;
      rf_wr_data_q  <= '0;
      rf_sp_wr_en_q <= 1'b0;
      rf_sp_data_q  <= '0;
    end else begin
      rf_wr_en_q    <= rf_wr_en_d;
      rf_wr_sel_q   <= rf_wr_sel_d;
      rf_wr_data_q  <= rf_wr_data_d;
      rf_sp_wr_en_q <= rf_sp_wr_en_d;
      rf_sp_data_q  <= rf_sp_data_d;
    end
  end

  // Bypass: output register is weakest, queue entries override oldest to youngest.
  always_comb begin
    fwd0_hit_o  = 1'b0;
    fwd0_data_o = '0;
    fwd1_hit_o  = 1'b0;
    fwd1_data_o = '0;
    if (rf_wr_en_q && (rf_wr_sel_q == rd0_sel_i)) begin
      fwd0_hit_o  = 1'b1;
      fwd0_data_o = rf_wr_data_q;
    end
    if (rf_wr_en_q && (rf_wr_sel_q == rd1_sel_i)) begin
      fwd1_hit_o  = 1'b1;
      fwd1_data_o = rf_wr_data_q;
    end
    for (int k = 0; k < WB_DEPTH; k++) begin
      if (q_age[k].valid && (q_age[k].sel == rd0_sel_i)) begin
        fwd0_hit_o  = 1'b1;
        fwd0_data_o = q_age[k].data;
      end
      if (q_age[k].valid && (q_age[k].sel == rd1_sel_i)) begin
        fwd1_hit_o  = 1'b1;
        fwd1_data_o = q_age[k].data;
      end
    end
  end

  assign rf_wr_en_o     = rf_wr_en_q;
  assign rf_wr_select_o = rf_wr_sel_q;
  assign rf_wr_data_o   = rf_wr_data_q;
  assign rf_sp_wr_en_o  = rf_sp_wr_en_q;
  assign rf_sp_data_o   = rf_sp_data_q;
  assign stall_o        = q_full;
  assign pending_o      = 2'(q_count);

  ex_wr_while_stalled: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(ex_wr_en_i && stall_o));

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: per-cycle vector table with a queue of expected
// post-edge outputs, followed by a hand-written mid-operation reset sequence.
module tb_rf_wb_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        ex_wr_en_i, ex_sp_wr_en_i, mem_wr_en_i;
  logic [3:0]  ex_wr_sel_i, mem_wr_sel_i, rd0_sel_i, rd1_sel_i;
  logic [31:0] ex_wr_data_i, ex_sp_data_i, mem_wr_data_i;
  logic        rf_wr_en_o, rf_sp_wr_en_o, fwd0_hit_o, fwd1_hit_o, stall_o;
  logic [3:0]  rf_wr_select_o;
  logic [31:0] rf_wr_data_o, rf_sp_data_o, fwd0_data_o, fwd1_data_o;
  logic [1:0]  pending_o;

  rf_wb_arbiter #(.WB_DEPTH(2)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .ex_wr_en_i(ex_wr_en_i), .ex_wr_sel_i(ex_wr_sel_i), .ex_wr_data_i(ex_wr_data_i),
    .ex_sp_wr_en_i(ex_sp_wr_en_i), .ex_sp_data_i(ex_sp_data_i),
    .mem_wr_en_i(mem_wr_en_i), .mem_wr_sel_i(mem_wr_sel_i), .mem_wr_data_i(mem_wr_data_i),
    .rd0_sel_i(rd0_sel_i), .rd1_sel_i(rd1_sel_i),
    .rf_wr_en_o(rf_wr_en_o), .rf_wr_select_o(rf_wr_select_o), .rf_wr_data_o(rf_wr_data_o),
    .rf_sp_wr_en_o(rf_sp_wr_en_o), .rf_sp_data_o(rf_sp_data_o),
    .fwd0_hit_o(fwd0_hit_o), .fwd0_data_o(fwd0_data_o),
    .fwd1_hit_o(fwd1_hit_o), .fwd1_data_o(fwd1_data_o),
    .stall_o(stall_o), .pending_o(pending_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        ex_en;   logic [3:0] ex_sel;  logic [31:0] ex_data;
    logic        mem_en;  logic [3:0] mem_sel; logic [31:0] mem_data;
    logic        sp_en;   logic [31:0] sp_data;
    logic [3:0]  rd0;     logic [3:0] rd1;
    logic        e_wr_en; logic [3:0] e_sel;   logic [31:0] e_data;
    logic [1:0]  e_pend;  logic e_stall;
    logic        e_f0hit; logic [31:0] e_f0data;
    logic        e_f1hit; logic [31:0] e_f1data;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  function automatic vec_t v(
    input logic ex_en, input logic [3:0] ex_sel, input logic [31:0] ex_data,
    input logic mem_en, input logic [3:0] mem_sel, input logic [31:0] mem_data,
    input logic sp_en, input logic [31:0] sp_data, input logic [3:0] rd0, input logic [3:0] rd1,
    input logic e_wr_en, input logic [3:0] e_sel, input logic [31:0] e_data,
    input logic [1:0] e_pend, input logic e_stall,
    input logic e_f0hit, input logic [31:0] e_f0data, input logic e_f1hit, input logic [31:0] e_f1data);
    vec_t r;
    r.ex_en = ex_en;   r.ex_sel = ex_sel;   r.ex_data = ex_data;
    r.mem_en = mem_en; r.mem_sel = mem_sel; r.mem_data = mem_data;
    r.sp_en = sp_en;   r.sp_data = sp_data; r.rd0 = rd0; r.rd1 = rd1;
    r.e_wr_en = e_wr_en; r.e_sel = e_sel; r.e_data = e_data;
    r.e_pend = e_pend; r.e_stall = e_stall;
    r.e_f0hit = e_f0hit; r.e_f0data = e_f0data; r.e_f1hit = e_f1hit; r.e_f1data = e_f1data;
    return r;
  endfunction

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  task automatic set_in(input logic ex_en, input logic [3:0] ex_sel, input logic [31:0] ex_data,
                        input logic mem_en, input logic [3:0] mem_sel, input logic [31:0] mem_data,
                        input logic sp_en, input logic [31:0] sp_data,
                        input logic [3:0] rd0, input logic [3:0] rd1);
    ex_wr_en_i = ex_en;   ex_wr_sel_i = ex_sel;   ex_wr_data_i = ex_data;
    mem_wr_en_i = mem_en; mem_wr_sel_i = mem_sel; mem_wr_data_i = mem_data;
    ex_sp_wr_en_i = sp_en; ex_sp_data_i = sp_data;
    rd0_sel_i = rd0; rd1_sel_i = rd1;
  endtask

  task automatic check_row(input int idx);
    vec_t e;
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL row%0d scoreboard: got empty queue, expected an entry", idx);
      return;
    end
    e = exp_q.pop_front();
    chk($sformatf("row%0d wr_en", idx), rf_wr_en_o, e.e_wr_en);
    if (e.e_wr_en) begin
      chk($sformatf("row%0d wr_sel", idx), rf_wr_select_o, e.e_sel);
      chk($sformatf("row%0d wr_data", idx), rf_wr_data_o, e.e_data);
    end
    chk($sformatf("row%0d sp_en", idx), rf_sp_wr_en_o, e.sp_en);
    chk($sformatf("row%0d sp_data", idx), rf_sp_data_o, e.sp_data);
    chk($sformatf("row%0d pending", idx), pending_o, e.e_pend);
    chk($sformatf("row%0d stall", idx), stall_o, e.e_stall);
    chk($sformatf("row%0d fwd0_hit", idx), fwd0_hit_o, e.e_f0hit);
    chk($sformatf("row%0d fwd0_data", idx), fwd0_data_o, e.e_f0data);
    chk($sformatf("row%0d fwd1_hit", idx), fwd1_hit_o, e.e_f1hit);
    chk($sformatf("row%0d fwd1_data", idx), fwd1_data_o, e.e_f1data);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    //          ex            mem            sp          rd0 rd1  | wr             pend stall f0        f1
    vecs.push_back(v(1,1,'h11,  0,0,0,       1,'h5000,   1, 2,    1,1,'h11,      0,0,  1,'h11, 0,0));
    vecs.push_back(v(1,2,'hAA,  1,3,'hBB,    0,0,        2, 3,    1,3,'hBB,      1,0,  1,'hAA, 1,'hBB));
    vecs.push_back(v(0,0,0,     0,0,0,       0,0,        2, 1,    1,2,'hAA,      0,0,  1,'hAA, 0,0));
    vecs.push_back(v(1,6,'h66,  1,5,'h55,    1,'h1234,   6, 5,    1,5,'h55,      1,0,  1,'h66, 1,'h55));
    vecs.push_back(v(1,8,'h88,  1,7,'h77,    0,0,        8, 6,    1,7,'h77,      2,1,  1,'h88, 1,'h66));
    vecs.push_back(v(0,0,0,     1,9,'h99,    0,0,        9, 7,    1,9,'h99,      2,1,  1,'h99, 0,0));
    vecs.push_back(v(0,0,0,     0,0,0,       0,0,        6, 8,    1,6,'h66,      1,0,  1,'h66, 1,'h88));
    vecs.push_back(v(1,10,'hA0, 0,0,0,       0,0,        10,8,    1,8,'h88,      1,0,  1,'hA0, 1,'h88));
    vecs.push_back(v(0,0,0,     0,0,0,       0,0,        10,0,    1,10,'hA0,     0,0,  1,'hA0, 0,0));
    vecs.push_back(v(0,0,0,     0,0,0,       0,0,        10,0,    0,0,0,         0,0,  0,0,    0,0));
    vecs.push_back(v(1,4,'h1,   1,5,'h55,    0,0,        4, 5,    1,5,'h55,      1,0,  1,'h1,  1,'h55));
    vecs.push_back(v(0,0,0,     1,4,'h2,     0,0,        4, 5,    1,4,'h2,       1,0,  1,'h2,  0,0));
    vecs.push_back(v(0,0,0,     0,0,0,       0,0,        4, 5,    0,0,0,         0,0,  0,0,    0,0));
    vecs.push_back(v(1,3,'h31,  1,1,'h10,    0,0,        3, 1,    1,1,'h10,      1,0,  1,'h31, 1,'h10));
    vecs.push_back(v(1,3,'h32,  1,2,'h20,    0,0,        3, 2,    1,2,'h20,      2,1,  1,'h32, 1,'h20));
    vecs.push_back(v(0,0,0,     0,0,0,       0,0,        3, 1,    1,3,'h31,      1,0,  1,'h32, 0,0));
    vecs.push_back(v(0,0,0,     0,0,0,       0,0,        3, 1,    1,3,'h32,      0,0,  1,'h32, 0,0));
    vecs.push_back(v(1,7,'h71,  1,7,'h70,    0,0,        7, 0,    1,7,'h70,      1,0,  1,'h71, 0,0));
    vecs.push_back(v(0,0,0,     0,0,0,       0,0,        7, 0,    1,7,'h71,      0,0,  1,'h71, 0,0));

    set_in(0,0,0, 0,0,0, 0,0, 0,0);
    rst_ni = 1'b0;
    repeat (2) @(negedge clk_i);
    chk("reset wr_en", rf_wr_en_o, 0);
    chk("reset wr_sel", rf_wr_select_o, 0);
    chk("reset wr_data", rf_wr_data_o, 0);
    chk("reset sp_en", rf_sp_wr_en_o, 0);
    chk("reset pending", pending_o, 0);
    chk("reset stall", stall_o, 0);
    chk("reset fwd0_hit", fwd0_hit_o, 0);
    rst_ni = 1'b1;

    foreach (vecs[i]) begin
      set_in(vecs[i].ex_en, vecs[i].ex_sel, vecs[i].ex_data,
             vecs[i].mem_en, vecs[i].mem_sel, vecs[i].mem_data,
             vecs[i].sp_en, vecs[i].sp_data, vecs[i].rd0, vecs[i].rd1);
      exp_q.push_back(vecs[i]);
      @(negedge clk_i);
      check_row(i);
    end

    // Fill the queue, then pull reset between edges.
    set_in(1,2,'h2, 1,1,'h1, 0,0, 0,0);
    @(negedge clk_i);
    set_in(1,4,'h4, 1,3,'h3, 1,'hBEEF, 0,0);
    @(negedge clk_i);
    set_in(0,0,0, 0,0,0, 0,0, 4,0);
    #1;
    chk("prerst pending", pending_o, 2);
    chk("prerst stall", stall_o, 1);
    chk("prerst wr_sel", rf_wr_select_o, 3);
    chk("prerst sp_data", rf_sp_data_o, 'hBEEF);
    chk("prerst fwd0_data", fwd0_data_o, 4);
    #1 rst_ni = 1'b0;
    #1;
    chk("rst wr_en", rf_wr_en_o, 0);
    chk("rst wr_sel", rf_wr_select_o, 0);
    chk("rst wr_data", rf_wr_data_o, 0);
    chk("rst sp_en", rf_sp_wr_en_o, 0);
    chk("rst sp_data", rf_sp_data_o, 0);
    chk("rst pending", pending_o, 0);
    chk("rst stall", stall_o, 0);
    chk("rst fwd0_hit", fwd0_hit_o, 0);
    chk("rst fwd0_data", fwd0_data_o, 0);
    @(negedge clk_i);
    set_in(1,5,'h5E, 0,0,0, 0,0, 0,0);
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("post-rst wr_en", rf_wr_en_o, 1);
    chk("post-rst wr_sel", rf_wr_select_o, 5);
    chk("post-rst wr_data", rf_wr_data_o, 'h5E);
    chk("post-rst pending", pending_o, 0);
    set_in(0,0,0, 0,0,0, 0,0, 0,0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk_i);
      chk($sformatf("post-rst idle%0d wr_en", c), rf_wr_en_o, 0);
      chk($sformatf("post-rst idle%0d pending", c), pending_o, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
